// File: rtl/loc_sampler_pkg.sv
// Shared fixed-weight sampler definitions: default parameter set, FSM states, clog2 helper.
package loc_sampler_pkg;

    localparam int unsigned M_DEF      = 13;
    localparam int unsigned N_DEF      = 4608;
    localparam int unsigned TAU_DEF    = 96;
    localparam int unsigned RAND_W_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_dual.sv
// Simple dual-port RAM: port 0 writes, port 1 registered read that holds when not enabled.
module mem_dual
    import loc_sampler_pkg::*;
#(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 96,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] din0,
    input  logic             re1,
    input  logic [AW-1:0]    addr1,
    output logic [WIDTH-1:0] dout1
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we0) mem[addr0] <= din0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout1 <= '0;
        end else if (re1) begin
            dout1 <= (32'(addr1) < DEPTH) ? mem[addr1] : '0;
        end
    end

endmodule

// File: rtl/loc_sampler.sv
// Rejection sampler filling a batch of TAU error locations below N from random words.
// Optional feature: define REJECT_CNT_EN to add the saturating reject_cnt output.
module loc_sampler
    import loc_sampler_pkg::*;
#(
    parameter int unsigned m      = M_DEF,
    parameter int unsigned N      = N_DEF,
    parameter int unsigned TAU    = TAU_DEF,
    parameter int unsigned RAND_W = RAND_W_DEF,
    parameter int unsigned LOGTAU = clog2(TAU)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RAND_W-1:0] rand_in,
    input  logic              rand_valid,
    output logic              rand_ready,
    input  logic              loc_rd_en,
    input  logic [LOGTAU-1:0] loc_rd_addr,
    output logic [m-1:0]      location,
    output logic              loc_ready,
    input  logic              collision,
    input  logic              consumed
`ifdef REJECT_CNT_EN
    ,
    output logic [15:0]       reject_cnt
`endif
);

    localparam logic [m:0] N_LIM = (m + 1)'(N);

    state_t            state;
    logic [LOGTAU-1:0] wr_ptr;
    logic [m-1:0]      cand;
    logic              in_range;
    logic              hs;
    logic              last;
    logic              we;
    logic              unused_rand;

    assign cand        = rand_in[m-1:0];
    assign unused_rand = ^rand_in;
    // Extra top bit lets N = 2^m accept every word.
    assign in_range    = {1'b0, cand} < N_LIM;
    assign hs          = rand_valid && rand_ready;
    assign last        = (wr_ptr == LOGTAU'(TAU - 1));
    assign we          = hs && in_range && !collision;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            loc_ready  <= 1'b0;
            rand_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wr_ptr     <= '0;
                        state      <= S_FILL;
                        rand_ready <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (collision) begin
                        wr_ptr    <= '0;
                        loc_ready <= 1'b0;
                    end else if (hs && in_range) begin
                        if (last) begin
                            wr_ptr     <= '0;
                            state      <= S_FULL;
                            loc_ready  <= 1'b1;
                            rand_ready <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (collision) begin
                        wr_ptr     <= '0;
                        loc_ready  <= 1'b0;
                        state      <= S_FILL;
                        rand_ready <= 1'b1;
                    end else if (consumed) begin
                        loc_ready <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    wr_ptr     <= '0;
                    loc_ready  <= 1'b0;
                    rand_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef REJECT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            reject_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            reject_cnt <= '0;
        end else if (hs && !in_range && reject_cnt != 16'hFFFF) begin
            reject_cnt <= reject_cnt + 16'd1;
        end
    end
`endif

    mem_dual #(
        .WIDTH(m),
        .DEPTH(TAU),
        .AW   (LOGTAU)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .we0  (we),
        .addr0(wr_ptr),
        .din0 (cand),
        .re1  (loc_rd_en),
        .addr1(loc_rd_addr),
        .dout1(location)
    );

endmodule

// File: tb/tb_loc_sampler.sv
// Self-checking bench for loc_sampler: vector table, hand sequences and randomized fills vs a queue model.
module tb_loc_sampler;

    localparam int unsigned M   = 13;
    localparam int unsigned N   = 4608;
    localparam int unsigned TAU = 96;
    localparam int unsigned RW  = 16;
    localparam int unsigned LT  = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] rand_in = '0;
    logic          rand_valid = 1'b0;
    logic          rand_ready;
    logic          loc_rd_en = 1'b0;
    logic [LT-1:0] loc_rd_addr = '0;
    logic [M-1:0]  location;
    logic          loc_ready;
    logic          collision = 1'b0;
    logic          consumed = 1'b0;
`ifdef REJECT_CNT_EN
    logic [15:0]   reject_cnt;
`endif

    loc_sampler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rand_in    (rand_in),
        .rand_valid (rand_valid),
        .rand_ready (rand_ready),
        .loc_rd_en  (loc_rd_en),
        .loc_rd_addr(loc_rd_addr),
        .location   (location),
        .loc_ready  (loc_ready),
        .collision  (collision),
        .consumed   (consumed)
`ifdef REJECT_CNT_EN
        ,
        .reject_cnt (reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        bit          keep;
        int          val;
    } vec_t;

    vec_t tbl[8];
    int   passed = 0;
    int   total = 0;
    int   q[$];
    int   saved[$];
    int   model_rej = 0;

    function automatic bit accepts(input logic [15:0] w);
        return int'(w % 16'd8192) < int'(N);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_rej(input string name);
`ifdef REJECT_CNT_EN
        check(name, reject_cnt, model_rej);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_consumed();
        consumed = 1'b1;
        tick();
        consumed = 1'b0;
    endtask

    // One handshake (sampler must be filling); model keeps the accepted words of the batch.
    task automatic send(input logic [15:0] w, input bit col);
        rand_in    = w;
        rand_valid = 1'b1;
        collision  = col;
        tick();
        rand_valid = 1'b0;
        collision  = 1'b0;
        if (!accepts(w)) model_rej++;
        if (col) q.delete();
        else if (accepts(w)) q.push_back(int'(w % 16'd8192));
    endtask

    task automatic fill_random(input int n);
        int acc;
        logic [15:0] w;
        acc = 0;
        while (acc < n) begin
            if ($urandom_range(0, 3) == 0) begin
                rand_in = 16'($urandom);
                tick();
            end
            w = 16'($urandom);
            send(w, 1'b0);
            if (accepts(w)) acc++;
        end
    endtask

    task automatic read_loc(input int a);
        loc_rd_en   = 1'b1;
        loc_rd_addr = LT'(a);
        tick();
        loc_rd_en = 1'b0;
    endtask

    task automatic readback(input string name);
        for (int i = 0; i < q.size(); i++) begin
            read_loc(i);
            check(name, location, q[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int rej_exp;
        int kept[$];

        tbl[0] = '{16'h1200, 1'b0, 0};
        tbl[1] = '{16'hFFFF, 1'b0, 0};
        tbl[2] = '{16'h0007, 1'b1, 7};
        tbl[3] = '{16'h2000, 1'b1, 0};
        tbl[4] = '{16'h11FF, 1'b1, 4607};
        tbl[5] = '{16'h1FFF, 1'b0, 0};
        tbl[6] = '{16'h3200, 1'b0, 0};
        tbl[7] = '{16'hE005, 1'b1, 5};

        tick();
        tick();
        rst = 1'b0;
        check("rst_loc_ready", loc_ready, 0);
        check("rst_rand_ready", rand_ready, 0);
        check("rst_location", location, 0);
        check_rej("rst_reject_cnt");

        // Ordered batch 0..95
        pulse_start();
        q.delete();
        model_rej = 0;
        check("start_rand_ready", rand_ready, 1);
        for (int i = 0; i < 95; i++) send(16'(i), 1'b0);
        check("pre_last_loc_ready", loc_ready, 0);
        send(16'd95, 1'b0);
        check("full_loc_ready", loc_ready, 1);
        check("full_rand_ready", rand_ready, 0);
        read_loc(5);
        check("read_addr5", location, 5);
        loc_rd_addr = 7'd9;
        tick();
        check("read_hold", location, 5);
        pulse_start();
        check("start_in_full_ignored", loc_ready, 1);
        readback("ordered_rd");

        // Table of mixed in-range / out-of-range words
        pulse_consumed();
        check("consumed_loc_ready", loc_ready, 0);
        check("consumed_rand_ready", rand_ready, 0);
        pulse_start();
        q.delete();
        model_rej = 0;
        check_rej("start_clears_rej");
        rej_exp = 0;
        kept.delete();
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].word, 1'b0);
            if (!tbl[i].keep) rej_exp++;
            else kept.push_back(tbl[i].val);
            check("tbl_rand_ready", rand_ready, 1);
`ifdef REJECT_CNT_EN
            check("tbl_reject_cnt", reject_cnt, rej_exp);
`endif
        end
        k = 0;
        foreach (kept[i]) begin
            read_loc(k);
            check("tbl_stored", location, kept[i]);
            k++;
        end
        fill_random(int'(TAU) - kept.size());
        check("tbl_full", loc_ready, 1);
        readback("tbl_rd");
        check_rej("tbl_rej_total");

        // Collision mid-fill at wr_ptr=40
        pulse_consumed();
        pulse_start();
        q.delete();
        model_rej = 0;
        fill_random(40);
        collision = 1'b1;
        tick();
        collision = 1'b0;
        q.delete();
        check("col40_rand_ready", rand_ready, 1);
        check("col40_loc_ready", loc_ready, 0);
        fill_random(95);
        check("col40_pre_full", loc_ready, 0);
        fill_random(1);
        check("col40_full", loc_ready, 1);
        readback("col40_rd");

        // Collision beats consumed in S_FULL
        collision = 1'b1;
        consumed  = 1'b1;
        tick();
        collision = 1'b0;
        consumed  = 1'b0;
        q.delete();
        check("col_cons_loc_ready", loc_ready, 0);
        check("col_cons_rand_ready", rand_ready, 1);
        fill_random(96);
        check("col_cons_refull", loc_ready, 1);
        check_rej("rej_kept_over_collision");

        // Collision together with the final accept
        pulse_consumed();
        pulse_start();
        q.delete();
        model_rej = 0;
        fill_random(95);
        send(16'd1234, 1'b1);
        check("col_last_loc_ready", loc_ready, 0);
        check("col_last_rand_ready", rand_ready, 1);
        fill_random(95);
        check("col_last_pre_full", loc_ready, 0);
        fill_random(1);
        check("col_last_full", loc_ready, 1);
        readback("col_last_rd");
        check_rej("col_last_rej");

        // Reset mid-fill at wr_ptr=50
        pulse_consumed();
        pulse_start();
        q.delete();
        fill_random(50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        model_rej = 0;
        check("rst50_rand_ready", rand_ready, 0);
        check("rst50_loc_ready", loc_ready, 0);
        check("rst50_location", location, 0);
        check_rej("rst50_rej");
        rand_in    = 16'd77;
        rand_valid = 1'b1;
        tick();
        rand_valid = 1'b0;
        check("idle_no_ready", rand_ready, 0);
        pulse_start();
        fill_random(96);
        check("rst50_full", loc_ready, 1);
        readback("rst50_rd");

        // Buffer survives reset
        saved = q;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        read_loc(3);
        check("buf_after_rst", location, saved[3]);

        // consumed with simultaneous start
        pulse_start();
        q.delete();
        model_rej = 0;
        fill_random(96);
        check("c40_full", loc_ready, 1);
        consumed = 1'b1;
        start    = 1'b1;
        tick();
        consumed = 1'b0;
        start    = 1'b0;
        check("c40_loc_ready", loc_ready, 0);
        check("c40_rand_ready", rand_ready, 0);
        tick();
        check("c40_still_idle", rand_ready, 0);
        pulse_start();
        check("c40_new_batch", rand_ready, 1);
        check_rej("c40_rej_cleared");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/loc_sampler.md
LOC_SAMPLER -- requirements
Module: loc_sampler

Interface
REQ-001 SHALL have parameter m, default 13: bit width of one error location.
REQ-002 SHALL have parameter N, default 4608: code length; valid locations are 0..N-1.
REQ-003 SHALL have parameter TAU, default 96: number of locations per batch.
REQ-004 SHALL have parameter RAND_W, default 16: random input word width, RAND_W >= m.
REQ-005 SHALL have parameter LOGTAU, default CLOG2(TAU): location buffer address width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1: one-cycle pulse that begins a new batch.
REQ-009 SHALL have port rand_in, input, RAND_W: random word.
REQ-010 SHALL have port rand_valid, input, 1: rand_in valid.
REQ-011 SHALL have port rand_ready, output, 1: sampler accepts rand_in this cycle.
REQ-012 SHALL have port loc_rd_en, input, 1: downstream location read strobe.
REQ-013 SHALL have port loc_rd_addr, input, LOGTAU: downstream read index.
REQ-014 SHALL have port location, output, m: location read data.
REQ-015 SHALL have port loc_ready, output, 1: level; a full batch of TAU locations is held.
REQ-016 SHALL have port collision, input, 1: downstream reports a duplicate location; discard the batch.
REQ-017 SHALL have port consumed, input, 1: one-cycle pulse; downstream has finished with the batch.

Function
REQ-018 SHALL implement FSM S_IDLE, S_FILL, S_FULL.
REQ-019 S_IDLE: on start SHALL clear wr_ptr to 0 and go to S_FILL; all other inputs except rst are ignored.
REQ-020 rand_ready SHALL be 1 only in S_FILL; a handshake occurs when rand_valid && rand_ready.
REQ-021 On a handshake, cand = rand_in[m-1:0]; if cand < N the sampler SHALL write cand to the buffer at wr_ptr and increment wr_ptr; otherwise the word SHALL be dropped with no write.
REQ-022 An accepted word written at wr_ptr == TAU-1 SHALL set wr_ptr to 0, move to S_FULL and raise loc_ready on the next cycle.
REQ-023 In S_FULL, loc_ready SHALL be 1 and rand_ready 0.
REQ-024 A read SHALL have 1-cycle latency: location equals buf[loc_rd_addr] on the cycle after loc_rd_en. location SHALL hold its value when loc_rd_en is 0. Reads are permitted in any state.
REQ-025 collision in S_FULL or S_FILL SHALL clear wr_ptr and loc_ready and go to S_FILL next cycle (refill). Collision takes priority over a simultaneous final accept.
REQ-026 consumed in S_FULL SHALL clear loc_ready and go to S_IDLE. If collision and consumed are asserted together, collision SHALL win.
REQ-027 start in S_FILL or S_FULL SHALL be ignored.
REQ-028 Comparison cand < N SHALL be unsigned at m bits; N = 2^m SHALL accept all words.

Reset
REQ-029 rst SHALL force S_IDLE, wr_ptr=0, loc_ready=0, rand_ready=0, location=0 on the next posedge. This applies mid-fill and mid-read.
REQ-030 Buffer contents SHALL NOT be cleared by rst.

Configuration
REQ-031 With REJECT_CNT_EN defined, the block SHALL add output reject_cnt[15:0]. It counts dropped words (cand >= N), saturates at 16'hFFFF, clears on rst and on start, and does NOT clear on collision.
REQ-032 Without REJECT_CNT_EN, neither the port nor the counter SHALL exist; all other behaviour is identical.

Structure
REQ-033 The CLOG2 macro and the default m/N/TAU for each parameter set SHALL live in the shared fixed-weight header/package.
REQ-034 The buffer SHALL use the codebase's mem_dual sub-module (WIDTH=m, DEPTH=TAU): port 0 for writes, port 1 for downstream reads. No other sub-module is used.

Verification
REQ-035 rst, start, then 96 words 0..95 with rand_valid=1 -> loc_ready=1 after the 96th handshake; reading addr 5 returns 5 one cycle later.
REQ-036 Word sequence 4608, 0xFFFF (low 13 bits = 8191), 7 -> only 7 is stored at index 0; with REJECT_CNT_EN, reject_cnt=2.
REQ-037 Collision pulse at wr_ptr=40 -> wr_ptr=0 next cycle, rand_ready stays 1, batch refills, loc_ready only after 96 further accepts.
REQ-038 Collision and the final accept in the same cycle -> loc_ready stays 0 and the FSM stays in S_FILL with wr_ptr=0.
REQ-039 rst asserted mid-fill at wr_ptr=50 -> S_IDLE, rand_ready=0; a following start refills from index 0.
REQ-040 consumed in S_FULL -> loc_ready=0 next cycle; a start in the same cycle as consumed is ignored; a later start begins a new batch.
